// File: rtl/dff_edge_filter_pkg.sv
// Shared types and helpers for the dff_edge_filter block.
package dff_edge_filter_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dff_edge_filter_if.sv
// Bus between the dff1 flop stage / status logic and dff_edge_filter.
interface dff_edge_filter_if #(parameter int CNT_W = 8);
  logic             q;
  logic             qb;
  logic             clr;
  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic             compl_err;

  modport master (
    output q, qb, clr,
    input  level, rise, fall, rise_cnt, fall_cnt, compl_err
  );

  modport slave (
    input  q, qb, clr,
    output level, rise, fall, rise_cnt, fall_cnt, compl_err
  );
endinterface

// File: rtl/dff_edge_filter_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;

  // Count register: clear beats increment, increment holds at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else if (clr) begin
      cnt_q <= {W{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dff_edge_filter.sv
// Debounces the q output of a dff1 stage into a level with edge pulses and counters.
// Optional q/qb complement check enabled by DFF_EDGE_FILTER_COMPL_CHECK_EN.
module dff_edge_filter
  import dff_edge_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  dff_edge_filter_if.slave bus
);

  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          compl_err_q;

  // Next-state decode for the debounce FSM.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (bus.q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
            stab_d  = {SW{1'b0}};
          end else begin
            state_d = RISE_PEND;
            stab_d  = SW'(1);
          end
        end else begin
          state_d = LOW;
        end
      end
      RISE_PEND: begin
        if (!bus.q) begin
          state_d = LOW;
          stab_d  = {SW{1'b0}};
        end else if (stab_q == STAB_LAST) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          stab_d  = {SW{1'b0}};
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      HIGH: begin
        if (!bus.q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
            stab_d  = {SW{1'b0}};
          end else begin
            state_d = FALL_PEND;
            stab_d  = SW'(1);
          end
        end else begin
          state_d = HIGH;
        end
      end
      FALL_PEND: begin
        if (bus.q) begin
          state_d = HIGH;
          stab_d  = {SW{1'b0}};
        end else if (stab_q == STAB_LAST) begin
          state_d = LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          stab_d  = {SW{1'b0}};
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      default: begin
        state_d = LOW;
        stab_d  = {SW{1'b0}};
        level_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered level/pulse outputs; reset abandons any pending edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOW;
      stab_q  <= {SW{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Counters step on the accepting edge so they update together with level.
  sat_counter #(.W(CNT_W)) u_rise_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .inc   (rise_d),
    .cnt   (bus.rise_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .inc   (fall_d),
    .cnt   (bus.fall_cnt)
  );

`ifdef DFF_EDGE_FILTER_COMPL_CHECK_EN
  // Sticky q/qb agreement error; clear beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      compl_err_q <= 1'b0;
    end else if (bus.clr) begin
      compl_err_q <= 1'b0;
    end else if (bus.q == bus.qb) begin
      compl_err_q <= 1'b1;
    end else begin
      compl_err_q <= compl_err_q;
    end
  end
`else
  assign compl_err_q = 1'b0;
`endif

  assign bus.level     = level_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.compl_err = compl_err_q;

endmodule

// File: tb/tb_dff_edge_filter.sv
// Directed self-checking bench for dff_edge_filter (STABLE_CYCLES=4, CNT_W=8).
module tb_dff_edge_filter;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  dff_edge_filter_if #(.CNT_W(8)) bus ();

  dff_edge_filter #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef DFF_EDGE_FILTER_COMPL_CHECK_EN
  localparam logic COMPL_ON = 1'b1;
`else
  localparam logic COMPL_ON = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    bus.q  = 1'b0;
    bus.qb = 1'b1;
    bus.clr = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic drive_q(input logic v);
    bus.q  = v;
    bus.qb = ~v;
  endtask

  int rise_seen;
  int fall_seen;
  int overlap_seen;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset   = 1'b0;
    bus.q   = 1'b0;
    bus.qb  = 1'b1;
    bus.clr = 1'b0;

    // Case 1: reset with q=1, then accept a rise; then glitch and accept a fall.
    drive_q(1'b1);
    repeat (3) step();
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_rise", bus.rise, 0);
    check_eq("rst_fall", bus.fall, 0);
    check_eq("rst_rcnt", bus.rise_cnt, 0);
    check_eq("rst_fcnt", bus.fall_cnt, 0);
    check_eq("rst_cerr", bus.compl_err, 0);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("c1_pend_level", bus.level, 0);
      check_eq("c1_pend_rise", bus.rise, 0);
    end
    step();
    check_eq("c1_level", bus.level, 1);
    check_eq("c1_rise", bus.rise, 1);
    check_eq("c1_rcnt", bus.rise_cnt, 1);
    step();
    check_eq("c1_rise_once", bus.rise, 0);
    check_eq("c1_level_hold", bus.level, 1);
    drive_q(1'b0);
    repeat (2) step();
    drive_q(1'b1);
    step();
    check_eq("c1_glitch_level", bus.level, 1);
    check_eq("c1_glitch_fall", bus.fall, 0);
    drive_q(1'b0);
    repeat (3) step();
    check_eq("c1_fall_pend", bus.level, 1);
    step();
    check_eq("c1_fall", bus.fall, 1);
    check_eq("c1_fall_level", bus.level, 0);
    check_eq("c1_fcnt", bus.fall_cnt, 1);

    // Case 2: only three q=1 samples never qualify.
    do_reset();
    drive_q(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("c2_rise", bus.rise, 0);
    end
    drive_q(1'b0);
    repeat (4) step();
    check_eq("c2_level", bus.level, 0);
    check_eq("c2_rcnt", bus.rise_cnt, 0);

    // Case 3: 300 full periods saturate both counters while pulses keep firing.
    do_reset();
    rise_seen    = 0;
    fall_seen    = 0;
    overlap_seen = 0;
    for (int p = 0; p < 300; p++) begin
      for (int h = 0; h < 10; h++) begin
        drive_q(h < 5);
        step();
        if (bus.rise === 1'b1) rise_seen++;
        if (bus.fall === 1'b1) fall_seen++;
        if ((bus.rise === 1'b1) && (bus.fall === 1'b1)) overlap_seen++;
      end
      if (p == 9) begin
        check_eq("c3_rcnt_10", bus.rise_cnt, 10);
        check_eq("c3_fcnt_10", bus.fall_cnt, 10);
      end
    end
    check_eq("c3_rcnt_sat", bus.rise_cnt, 255);
    check_eq("c3_fcnt_sat", bus.fall_cnt, 255);
    check_eq("c3_rise_pulses", rise_seen, 300);
    check_eq("c3_fall_pulses", fall_seen, 300);
    check_eq("c3_overlap", overlap_seen, 0);

    // Case 4: clear on the accepting edge zeroes the count but not the pulse.
    do_reset();
    drive_q(1'b1);
    repeat (3) step();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check_eq("c4_rise", bus.rise, 1);
    check_eq("c4_rcnt", bus.rise_cnt, 0);
    check_eq("c4_level", bus.level, 1);
    step();
    check_eq("c4_rcnt_after", bus.rise_cnt, 0);

    // Case 5: reset during a pending rise abandons it.
    do_reset();
    drive_q(1'b1);
    repeat (2) step();
    reset = 1'b0;
    step();
    check_eq("c5_rst_level", bus.level, 0);
    check_eq("c5_rst_rise", bus.rise, 0);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("c5_fresh_level", bus.level, 0);
      check_eq("c5_fresh_rise", bus.rise, 0);
    end
    step();
    check_eq("c5_level", bus.level, 1);
    check_eq("c5_rise", bus.rise, 1);

    // Case 6: complement check is sticky until clear; clear beats a same-cycle set.
    do_reset();
    bus.q  = 1'b1;
    bus.qb = 1'b1;
    step();
    check_eq("c6_set", bus.compl_err, 32'(COMPL_ON));
    drive_q(1'b1);
    repeat (2) step();
    check_eq("c6_sticky", bus.compl_err, 32'(COMPL_ON));
    bus.clr = 1'b1;
    step();
    check_eq("c6_clr", bus.compl_err, 0);
    bus.qb = 1'b1;
    step();
    check_eq("c6_clr_wins", bus.compl_err, 0);
    bus.clr = 1'b0;
    drive_q(1'b1);
    step();
    check_eq("c6_idle", bus.compl_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
